// File: rtl/label_map_packer_pkg.sv
// rtl/label_map_packer_pkg.sv - shared sizes and state encoding for the label map packer
package label_map_packer_pkg;

  localparam int IMG_W  = 32;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int NBYTES = NPIX / 8;
  localparam int PIX_W  = $clog2(NPIX);
  localparam int BYTE_W = $clog2(NBYTES);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/label_map_packer_bit_packer.sv
// rtl/label_map_packer_bit_packer.sv - collects one bit per valid into bytes, LSB first
// byte_valid/byte_out/byte_idx are registered at the edge that takes in the 8th bit.
module bit_packer
  import label_map_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_bit_in,
  input  logic              i_bit_valid,
  input  logic              i_clear,
  output logic [7:0]        o_byte_out,
  output logic              o_byte_valid,
  output logic [BYTE_W-1:0] o_byte_idx
);

  logic [6:0]        r_sr;
  logic [2:0]        r_bitcnt;
  logic [BYTE_W-1:0] r_idx;
  logic [7:0]        r_byte_out;
  logic              r_byte_valid;
  logic [BYTE_W-1:0] r_byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr         <= '0;
      r_bitcnt     <= '0;
      r_idx        <= '0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_byte_idx   <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      if (i_clear) begin
        r_sr     <= '0;
        r_bitcnt <= '0;
        r_idx    <= '0;
      end else if (i_bit_valid) begin
        // Shift in from the top so the oldest pixel lands in bit 0.
        r_sr     <= {i_bit_in, r_sr[6:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_byte_out   <= {i_bit_in, r_sr};
          r_byte_valid <= 1'b1;
          r_byte_idx   <= r_idx;
          r_idx        <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_byte_out   = r_byte_out;
  assign o_byte_valid = r_byte_valid;
  assign o_byte_idx   = r_byte_idx;

endmodule

// File: rtl/label_map_packer.sv
// rtl/label_map_packer.sv - reads the 32x32 label map and repacks it as a 1-bit image
// Also reports the largest label and the count of nonzero labels for each pass.
module label_map_packer
  import label_map_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic [PIX_W-1:0]  o_sram_a,
  input  logic [7:0]        i_sram_q,
  output logic [BYTE_W-1:0] o_img_a,
  output logic [7:0]        o_img_d,
  output logic              o_img_wen,
  output logic              o_busy,
  output logic              o_finish,
  output logic [7:0]        o_label_max,
  output logic [PIX_W:0]    o_pix_cnt
);

  state_t           r_state;
  logic [PIX_W-1:0] r_addr;
  logic             r_v1;
  logic             r_v2;
  logic             r_busy;
  logic             r_finish;
  logic [7:0]       r_max;
  logic [PIX_W:0]   r_cnt;

  logic             w_launch;
  logic             w_nonzero;
  logic [7:0]       w_byte;
  logic             w_byte_valid;
  logic [BYTE_W-1:0] w_byte_idx;

  assign w_launch  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_nonzero = (i_sram_q != 8'd0);

  // r_v1: an address was issued last edge; r_v2: its data is on sram_q now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_max    <= '0;
      r_cnt    <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v2) begin
        if (w_nonzero) r_cnt <= r_cnt + 1'b1;
        if (i_sram_q > r_max) r_max <= i_sram_q;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state  <= S_READ;
            r_addr   <= '0;
            r_v1     <= 1'b1;
            r_busy   <= 1'b1;
            r_finish <= 1'b0;
            r_max    <= '0;
            r_cnt    <= '0;
          end
        end
        S_READ: begin
          if (r_addr == LAST_PIX) begin
            r_state <= S_DRAIN;
            r_v1    <= 1'b0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!r_v1 && !r_v2) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_finish <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  bit_packer u_bit_packer (
    .clk          (clk),
    .reset        (reset),
    .i_bit_in     (w_nonzero),
    .i_bit_valid  (r_v2),
    .i_clear      (w_launch),
    .o_byte_out   (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_byte_idx   (w_byte_idx)
  );

  assign o_sram_a    = r_addr;
  assign o_img_a     = w_byte_idx;
  assign o_img_d     = w_byte;
  assign o_img_wen   = ~w_byte_valid;
  assign o_busy      = r_busy;
  assign o_finish    = r_finish;
  assign o_label_max = r_max;
  assign o_pix_cnt   = r_cnt;

endmodule

// File: tb/tb_label_map_packer.sv
// tb/tb_label_map_packer.sv - scoreboard bench for label_map_packer
module tb_label_map_packer;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [9:0]  o_sram_a;
  logic [7:0]  i_sram_q;
  logic [6:0]  o_img_a;
  logic [7:0]  o_img_d;
  logic        o_img_wen;
  logic        o_busy;
  logic        o_finish;
  logic [7:0]  o_label_max;
  logic [10:0] o_pix_cnt;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    int         j;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] mem [0:1023];
  int         n_cmp = 0;
  int         n_err = 0;
  int         edge_n = 0;
  int         e0 = 0;
  int         exp_pix;
  int         exp_max;

  label_map_packer dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .o_sram_a    (o_sram_a),
    .i_sram_q    (i_sram_q),
    .o_img_a     (o_img_a),
    .o_img_d     (o_img_d),
    .o_img_wen   (o_img_wen),
    .o_busy      (o_busy),
    .o_finish    (o_finish),
    .o_label_max (o_label_max),
    .o_pix_cnt   (o_pix_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    i_sram_q <= mem[o_sram_a];
  end

  // Every write strobe must match the next expected write, including its edge index.
  always @(negedge clk) begin
    if (o_img_wen === 1'b0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h at j=%0d, required no write", o_img_a, o_img_d, edge_n - e0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (o_img_a !== e.a || o_img_d !== e.d || (edge_n - e0) != e.j) begin
          n_err++;
          $display("FAIL img_write: got addr=%0d data=%02h j=%0d, required addr=%0d data=%02h j=%0d",
                   o_img_a, o_img_d, edge_n - e0, e.a, e.d, e.j);
        end
      end
    end
  end

  task automatic push_expected(input int last_m);
    exp_pix = 0;
    exp_max = 0;
    for (int p = 0; p < 1024; p++) begin
      if (mem[p] != 8'd0) exp_pix++;
      if (int'(mem[p]) > exp_max) exp_max = int'(mem[p]);
    end
    for (int m = 0; m <= last_m; m++) begin
      wr_t e;
      e.a = 7'(m);
      e.d = 8'd0;
      for (int b = 0; b < 8; b++) e.d[b] = (mem[8*m+b] != 8'd0);
      e.j = 8*m + 9;
      sb.push_back(e);
    end
  endtask

  task automatic start_pass();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    e0 = edge_n;
  endtask

  task automatic wait_finish(input int poke_at, output int fin, output logic busy_1025);
    fin = -1;
    busy_1025 = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (edge_n - e0 == poke_at) i_start = 1'b1;
      else i_start = 1'b0;
      if (edge_n - e0 == 1025) busy_1025 = o_busy;
      if (o_finish === 1'b1) begin
        fin = edge_n - e0;
        break;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({o_sram_a, o_img_a, o_img_d, o_img_wen, o_busy, o_finish, o_label_max, o_pix_cnt} !==
        {10'd0, 7'd0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 11'd0}) begin
      n_err++;
      $display("FAIL reset_state: got sram_a=%0d img_a=%0d img_d=%02h wen=%b busy=%b fin=%b max=%0d cnt=%0d, required 0 0 00 1 0 0 0 0",
               o_sram_a, o_img_a, o_img_d, o_img_wen, o_busy, o_finish, o_label_max, o_pix_cnt);
    end
  endtask

  task automatic test_pass(input string name, input int poke_at);
    int   fin;
    logic b1025;
    push_expected(127);
    start_pass();
    n_cmp++;
    if (o_busy !== 1'b1 || o_sram_a !== 10'd0) begin
      n_err++;
      $display("FAIL %s_start: got busy=%b sram_a=%0d, required busy=1 sram_a=0", name, o_busy, o_sram_a);
    end
    wait_finish(poke_at, fin, b1025);
    n_cmp++;
    if (fin != 1026 || b1025 !== 1'b1) begin
      n_err++;
      $display("FAIL %s_finish: got finish at j=%0d busy@1025=%b, required j=1026 busy@1025=1", name, fin, b1025);
    end
    n_cmp++;
    if (o_busy !== 1'b0 || o_img_wen !== 1'b1 || o_sram_a !== 10'd1023) begin
      n_err++;
      $display("FAIL %s_done_outputs: got busy=%b wen=%b sram_a=%0d, required 0 1 1023", name, o_busy, o_img_wen, o_sram_a);
    end
    n_cmp++;
    if (int'(o_pix_cnt) != exp_pix || int'(o_label_max) != exp_max) begin
      n_err++;
      $display("FAIL %s_stats: got pix_cnt=%0d label_max=%0d, required %0d %0d", name, o_pix_cnt, o_label_max, exp_pix, exp_max);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_writes_missing: got %0d outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (o_finish !== 1'b1 || int'(o_pix_cnt) != exp_pix) begin
      n_err++;
      $display("FAIL %s_hold: got finish=%b pix_cnt=%0d, required 1 %0d", name, o_finish, o_pix_cnt, exp_pix);
    end
  endtask

  task automatic test_all_zero();
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
    test_pass("all_zero", -5);
  endtask

  task automatic test_all_one();
    for (int p = 0; p < 1024; p++) mem[p] = 8'd1;
    test_pass("all_one", -5);
  endtask

  task automatic test_single_pixel();
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
    mem[9] = 8'd5;
    test_pass("single_pixel", -5);
  endtask

  task automatic test_ramp();
    for (int p = 0; p < 1024; p++) mem[p] = 8'(p);
    test_pass("ramp", -5);
  endtask

  task automatic test_reset_mid_pass();
    logic saw_fin;
    for (int p = 0; p < 1024; p++) mem[p] = 8'(p * 7 + 3);
    push_expected(61);
    start_pass();
    while (edge_n - e0 < 500) @(negedge clk);
    reset = 1'b1;
    #1;
    test_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_writes_before: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    saw_fin = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (o_finish !== 1'b0 || o_busy !== 1'b0) saw_fin = 1'b1;
    end
    n_cmp++;
    if (saw_fin) begin
      n_err++;
      $display("FAIL reset_mid_idle: got finish/busy high after reset, required both 0");
    end
    test_pass("after_reset", -5);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 1024; p++) mem[p] = 8'($urandom_range(0, 3));
    test_pass("poke300", 300);
    push_expected(127);
    start_pass();
    n_cmp++;
    if (o_finish !== 1'b0 || o_pix_cnt !== 11'd0 || o_label_max !== 8'd0 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_clear: got finish=%b pix_cnt=%0d max=%0d busy=%b, required 0 0 0 1",
               o_finish, o_pix_cnt, o_label_max, o_busy);
    end
    sb.delete();
    e0 = e0 - 1026;
    push_expected(127);
    for (int i = 0; i < sb.size(); i++) sb[i].j = sb[i].j + 1026;
    begin
      int   fin;
      logic b1025;
      wait_finish(-5, fin, b1025);
      n_cmp++;
      if (fin != 2052) begin
        n_err++;
        $display("FAIL second_pass_finish: got j=%0d, required 1026", fin - 1026);
      end
      n_cmp++;
      if (int'(o_pix_cnt) != exp_pix || int'(o_label_max) != exp_max || sb.size() != 0) begin
        n_err++;
        $display("FAIL second_pass_result: got pix_cnt=%0d max=%0d outstanding=%0d, required %0d %0d 0",
                 o_pix_cnt, o_label_max, sb.size(), exp_pix, exp_max);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    for (int p = 0; p < 1024; p++) mem[p] = 8'd0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_all_zero();
    test_all_one();
    test_single_pixel();
    test_ramp();
    test_reset_mid_pass();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
